// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, FSM states and result-pair type for the conv write-back stage
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WR1,
        WB_WR2
    } wb_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum1;
        logic [ADDR_W-1:0] addr1;
        logic [DATA_W-1:0] sum2;
        logic [ADDR_W-1:0] addr2;
    } pair_t;

    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/conv_writeback_if.sv
// rtl/conv_writeback_if.sv - result-pair input handshake and feature-map memory write bus
interface conv_writeback_if;
    import conv_pkg::*;

    logic              i_valid;
    logic [DATA_W-1:0] i_sum1;
    logic [DATA_W-1:0] i_sum2;
    logic [ADDR_W-1:0] i_dest_addr1;
    logic [ADDR_W-1:0] i_dest_addr2;
    logic              o_ready;
    logic              i_mem_busy;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;

    modport slave (
        input  i_valid, i_sum1, i_sum2, i_dest_addr1, i_dest_addr2, i_mem_busy,
        output o_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_valid, i_sum1, i_sum2, i_dest_addr1, i_dest_addr2, i_mem_busy,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/conv_pair_fifo.sv
// rtl/conv_pair_fifo.sv - synchronous result-pair FIFO, extra pointer bit separates full from empty
module conv_pair_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  pair_t                    wdata,
    output pair_t                    rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pair_t       mem_q [DEPTH];
    pair_t       mem_d [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset: it is only read while the pointers say it is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/conv_writeback.sv
// rtl/conv_writeback.sv - queues result pairs and serialises them as memory writes; RELU_EN clamps negatives
module conv_writeback
    import conv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    conv_writeback_if.slave  wb,
    output logic             o_idle,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t         state_q, state_d;
    pair_t             hold_q, hold_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              idle_q, idle_d;

    pair_t             in_pair;
    pair_t             head;
    pair_t             head_cond;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              load;

    assign in_pair.sum1  = wb.i_sum1;
    assign in_pair.addr1 = wb.i_dest_addr1;
    assign in_pair.sum2  = wb.i_sum2;
    assign in_pair.addr2 = wb.i_dest_addr2;

    assign push       = wb.i_valid && !full;
    assign wb.o_ready = !full;

    conv_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_pair),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        head_cond = head;
`ifdef RELU_EN
        head_cond.sum1 = relu(head.sum1);
        head_cond.sum2 = relu(head.sum2);
`endif
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q | (wb.i_valid && full);
        load    = 1'b0;

        case (state_q)
            WB_IDLE: begin
                we_d = 1'b0;
                load = !empty;
            end
            WB_WR1: begin
                if (!wb.i_mem_busy) begin
                    state_d = WB_WR2;
                    addr_d  = hold_q.addr2;
                    wdata_d = hold_q.sum2;
                end
            end
            WB_WR2: begin
                if (!wb.i_mem_busy) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = WB_IDLE;
                        we_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = WB_IDLE;
                we_d    = 1'b0;
            end
        endcase

        // Popping straight out of WR2 keeps the write port busy with no idle bubble.
        pop = load;
        if (load) begin
            hold_d  = head_cond;
            state_d = WB_WR1;
            we_d    = 1'b1;
            addr_d  = head_cond.addr1;
            wdata_d = head_cond.sum1;
        end

        count_next = count + CNT_W'(push) - CNT_W'(pop);
        idle_d     = (state_d == WB_IDLE) && (count_next == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WB_IDLE;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            idle_q  <= idle_d;
        end
    end

    assign wb.o_mem_we    = we_q;
    assign wb.o_mem_addr  = addr_q;
    assign wb.o_mem_wdata = wdata_q;
    assign o_idle         = idle_q;
    assign o_overflow     = ovf_q;

endmodule
